// File: rtl/dcache.sv
// dcache: direct-mapped, write-back data cache, 8 blocks x 4 bytes.
// Address split: tag[7:5] | index[4:2] | offset[1:0].
// A miss stalls the CPU (BUSYWAIT). The victim block is written back if it is
// dirty, then the requested block is fetched and installed.
// Optional build macro: DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Per-block status and storage.
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags   [8];
    logic [31:0] blocks [8];

    // Block captured from memory at the end of FETCH, installed in UPDATE.
    logic [31:0] fetch_buf;

    // Address fields of the current CPU request.
    logic [2:0] addr_tag;
    logic [2:0] addr_index;
    logic [1:0] addr_offset;

    assign addr_tag    = ADDRESS[7:5];
    assign addr_index  = ADDRESS[4:2];
    assign addr_offset = ADDRESS[1:0];

    logic        request;
    logic        hit;
    logic        write_hit;
    logic [31:0] sel_block;
    logic [7:0]  sel_byte;

    // A simultaneous READ and WRITE is served as a read, so a store only
    // happens when READ is low.
    assign request   = READ | WRITE;
    assign hit       = valid[addr_index] && (tags[addr_index] == addr_tag);
    assign write_hit = (state == IDLE) && WRITE && !READ && hit && !RESET;
    assign sel_block = blocks[addr_index];
    assign sel_byte  = sel_block[{addr_offset, 3'b000} +: 8];

    // Load data and stall are combinational so a hit costs no cycles.
    assign READDATA = (!RESET && READ && hit) ? sel_byte : 8'h00;
    assign BUSYWAIT = !RESET && request && !((state == IDLE) && hit);

    // State register.
    // NOTE: sequential state is always updated with non-blocking (<=)
    // assignments so every flop samples pre-edge values, independent of
    // process evaluation order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and memory-side outputs, decoded from state.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state    = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'h00;
        MEM_WRITEDATA = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    if (valid[addr_index] && dirty[addr_index]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tags[addr_index], addr_index};
                MEM_WRITEDATA = blocks[addr_index];
                if (!MEM_BUSYWAIT) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {addr_tag, addr_index};
                if (!MEM_BUSYWAIT) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Valid and dirty bits: cleared by reset, set by fill and store hits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= 8'h00;
            dirty <= 8'h00;
        end else if (state == UPDATE) begin
            valid[addr_index] <= 1'b1;
            dirty[addr_index] <= 1'b0;
        end else if (write_hit) begin
            dirty[addr_index] <= 1'b1;
        end
    end

    // Data/tag arrays and the fetch buffer.
    // NOTE: these arrays are deliberately not reset; the valid bits make
    // their contents irrelevant after reset, and leaving them unreset lets
    // them map onto plain storage.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if ((state == FETCH) && !MEM_BUSYWAIT) begin
                fetch_buf <= MEM_READDATA;
            end
            if (state == UPDATE) begin
                blocks[addr_index] <= fetch_buf;
                tags[addr_index]   <= addr_tag;
            end else if (write_hit) begin
                blocks[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The IDLE cycle right after a fill re-serves the missed access, so it
    // is not counted as a fresh hit.
    logic filled;
    logic hit_event;
    logic miss_event;

    assign hit_event  = (state == IDLE) && request && hit && !filled;
    assign miss_event = (state == IDLE) && request && !hit;

    // Saturating hit/miss counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            filled     <= 1'b0;
            HIT_COUNT  <= 16'h0000;
            MISS_COUNT <= 16'h0000;
        end else begin
            filled <= (state == UPDATE);
            if (hit_event && (HIT_COUNT != 16'hFFFF)) begin
                HIT_COUNT <= HIT_COUNT + 16'h0001;
            end
            if (miss_event && (MISS_COUNT != 16'hFFFF)) begin
                MISS_COUNT <= MISS_COUNT + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scoreboard bench for dcache. Stimulus pushes expected CPU and
// memory responses into queues; monitors pop and compare when the DUT
// completes an access or a memory transaction.
module tb_dcache;

    localparam int LAT = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model: fixed latency LAT per transaction ----
    logic [31:0] mem [64];
    int          mcnt = 0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != LAT - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {4{i[7:0]}};
        end
        mem[1] = 32'hDDCCBBAA;
        mem[7] = 32'hD0C0B0A0;
        mem[9] = 32'h44332211;
        forever begin
            @(posedge CLK);
            if (MEM_READ || MEM_WRITE) begin
                if (mcnt == LAT - 1) begin
                    if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                    mcnt <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else begin
                mcnt <= 0;
            end
        end
    end

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [7:0] rdata;
        int         stall;
    } cpu_exp_t;

    typedef struct {
        logic       wr;
        logic [5:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    // CPU-side monitor: counts stall cycles, compares on completion.
    int       stall_cnt = 0;
    cpu_exp_t cpu_e;
    always @(negedge CLK) begin
        if (RESET || !(READ || WRITE)) begin
            stall_cnt = 0;
        end else if (BUSYWAIT) begin
            stall_cnt++;
        end else begin
            if (cpu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_unexpected: access at %h completed with nothing expected", ADDRESS);
            end else begin
                cpu_e = cpu_q.pop_front();
                check($sformatf("readdata@%h", ADDRESS), {24'h0, READDATA}, {24'h0, cpu_e.rdata});
                check($sformatf("stall@%h", ADDRESS), stall_cnt, cpu_e.stall);
            end
            stall_cnt = 0;
        end
    end

    // Memory-side monitor: compares each completing transaction.
    mem_exp_t mem_e;
    always @(negedge CLK) begin
        if (!RESET && (MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            if (mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: transaction at %h with nothing expected", MEM_ADDRESS);
            end else begin
                mem_e = mem_q.pop_front();
                check("mem_write_flag", {31'h0, MEM_WRITE}, {31'h0, mem_e.wr});
                check("mem_read_flag", {31'h0, MEM_READ}, {31'h0, !mem_e.wr});
                check("mem_address", {26'h0, MEM_ADDRESS}, {26'h0, mem_e.addr});
                if (mem_e.wr) check("mem_writedata", MEM_WRITEDATA, mem_e.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        mem_q.push_back('{wr: wr, addr: addr, data: data});
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input int exp_stall);
        cpu_q.push_back('{rdata: exp_rd, stall: exp_stall});
        @(posedge CLK);
        #1;
        READ = rd;
        WRITE = wr;
        ADDRESS = addr;
        WRITEDATA = wd;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
        end
        if (BUSYWAIT) begin
            checks++;
            errors++;
            $display("FAIL timeout: access at %h still stalled after 60 cycles", addr);
        end
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h05;
        WRITEDATA = 8'h00;

        // Reset state, with a request held during reset.
        @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
        check("reset_readdata", {24'h0, READDATA}, 32'h0);
        check("reset_mem_read", {31'h0, MEM_READ}, 32'h0);
        check("reset_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        check("reset_mem_address", {26'h0, MEM_ADDRESS}, 32'h0);
        check("reset_mem_writedata", MEM_WRITEDATA, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ = 1'b0;

        // Clean miss: 1 IDLE + 5 FETCH + 1 UPDATE stall cycles.
        expect_mem(1'b0, 6'h01, 32'h0);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 7);
        // Read hit, other byte of the same block.
        access(1'b1, 1'b0, 8'h07, 8'h00, 8'hDD, 0);
        // Write hit: no stall, READDATA stays 0 with READ low.
        access(1'b0, 1'b1, 8'h04, 8'h5A, 8'h00, 0);
        access(1'b1, 1'b0, 8'h04, 8'h00, 8'h5A, 0);
        // Dirty miss on the same index: write back, then fetch block 0x09.
        expect_mem(1'b1, 6'h01, 32'hDDCCBB5A);
        expect_mem(1'b0, 6'h09, 32'h0);
        access(1'b1, 1'b0, 8'h24, 8'h00, 8'h11, 12);
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        check("hit_count", {16'h0, HIT_COUNT}, 32'd3);
        check("miss_count", {16'h0, MISS_COUNT}, 32'd2);
`endif
        // READ and WRITE together act as a read; the byte is left unchanged.
        access(1'b1, 1'b1, 8'h25, 8'hFF, 8'h22, 0);
        access(1'b1, 1'b0, 8'h25, 8'h00, 8'h22, 0);

        // Reset in the middle of a clean-miss fetch.
        @(posedge CLK);
        #1;
        READ = 1'b1;
        ADDRESS = 8'h05;
        repeat (3) @(negedge CLK);
        check("fetch_mem_read", {31'h0, MEM_READ}, 32'h1);
        check("fetch_mem_address", {26'h0, MEM_ADDRESS}, 32'h01);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        READ = 1'b0;
        @(negedge CLK);
        check("in_reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("post_reset_mem_read", {31'h0, MEM_READ}, 32'h0);
        check("post_reset_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        check("post_reset_busywait", {31'h0, BUSYWAIT}, 32'h0);
        check("post_reset_readdata", {24'h0, READDATA}, 32'h0);
`ifdef DCACHE_STATS_EN
        check("post_reset_hit_count", {16'h0, HIT_COUNT}, 32'd0);
        check("post_reset_miss_count", {16'h0, MISS_COUNT}, 32'd0);
`endif

        // After reset 8'h05 misses again and sees the written-back block.
        expect_mem(1'b0, 6'h01, 32'h0);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 7);
        // Write miss to an invalid block: allocate, then store.
        expect_mem(1'b0, 6'h07, 32'h0);
        access(1'b0, 1'b1, 8'h1F, 8'h77, 8'h00, 7);
        access(1'b1, 1'b0, 8'h1F, 8'h00, 8'h77, 0);
        access(1'b1, 1'b0, 8'h1C, 8'h00, 8'hA0, 0);

        repeat (4) @(negedge CLK);
        check("cpu_queue_drained", cpu_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
